// File: rtl/alu_div_pkg.sv
// alu_div_pkg: shared state encoding, default width and counter sizing for the divider
package alu_div_pkg;
    typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;
    localparam int DIV_W = 32;
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one restoring shift-subtract iteration on unsigned magnitudes
module div_step
    import alu_div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] a_next,
    output logic [WIDTH-1:0] q_next
);
    logic [WIDTH:0] a_sh;
    logic           ge;
    assign a_sh   = {a, q[WIDTH-1]};
    assign ge     = a_sh >= {1'b0, m};
    assign a_next = ge ? a_sh[WIDTH-1:0] - m : a_sh[WIDTH-1:0];
    assign q_next = {q[WIDTH-2:0], ge};
endmodule

// File: rtl/divide.sv
// divide: sequential WIDTH-bit signed/unsigned restoring divider (quotient->LO, remainder->HI); define DIVIDE_ZERO_FAST_EN to skip iteration on a zero divisor
module divide
    import alu_div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = cnt_w(WIDTH);
    state_t           state;
    logic [WIDTH-1:0] a_in, b_in, acc, q, m, a_nxt, q_nxt;
    logic [CW-1:0]    n;
    logic             sg, q_neg, r_neg, dz;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
        return (s && x[WIDTH-1]) ? -x : x;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .a(acc),
        .q(q),
        .m(m),
        .a_next(a_nxt),
        .q_next(q_nxt)
    );

    // capture -> magnitudes -> WIDTH iterations -> sign fix-up; a zero divisor overrides the fix-up results
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            a_in        <= '0;
            b_in        <= '0;
            acc         <= '0;
            q           <= '0;
            m           <= '0;
            n           <= '0;
            sg          <= 1'b0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dz          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    a_in        <= dividend;
                    b_in        <= divisor;
                    sg          <= signed_op;
                    q_neg       <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    r_neg       <= signed_op & dividend[WIDTH-1];
                    dz          <= divisor == '0;
                    div_by_zero <= 1'b0;
`ifdef DIVIDE_ZERO_FAST_EN
                    state       <= (divisor == '0) ? FIX : PREP;
                    busy        <= divisor != '0;
`else
                    state       <= PREP;
                    busy        <= 1'b1;
`endif
                end
                PREP: begin
                    acc   <= '0;
                    q     <= mag(a_in, sg);
                    m     <= mag(b_in, sg);
                    n     <= CW'(WIDTH);
                    state <= ITER;
                end
                ITER: begin
                    acc   <= a_nxt;
                    q     <= q_nxt;
                    n     <= n - 1'b1;
                    state <= (n == CW'(1)) ? FIX : ITER;
                end
                FIX: begin
                    quotient    <= dz ? '1 : (q_neg ? -q : q);
                    remainder   <= dz ? a_in : (r_neg ? -acc : acc);
                    div_by_zero <= dz;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_divide.sv
// tb_divide: randomized scoreboard bench for divide against an arithmetic reference model
module tb_divide;
    localparam int W = 32;
    localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

    logic         clock = 1'b0, clear_n = 1'b0, start = 1'b0, signed_op = 1'b0;
    logic [W-1:0] dividend = '0, divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           cyc;
        int           bsy;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0, n_cmp = 0, n_bad = 0, busy_cnt = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    divide #(.WIDTH(W)) dut (
        .clock(clock),
        .clear_n(clear_n),
        .start(start),
        .signed_op(signed_op),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, want %h", nm, cyc, act, want);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        e.cyc = 0;
        e.bsy = 0;
        e.dz  = (b == '0);
        if (b == '0) begin
            e.q = '1;
            e.r = a;
        end else if (s && a == MIN && b == '1) begin
            e.q = MIN;
            e.r = '0;
        end else if (s) begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    always @(negedge clock) begin
        if (!clear_n) busy_cnt = 0;
        else if (done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done at cycle %0d: got done=1, want no done", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_by_zero", W'(div_by_zero), W'(e.dz));
                chk("done_cycle", W'(cyc), W'(e.cyc));
                chk("busy_cycles", W'(busy_cnt), W'(e.bsy));
                chk("busy_at_done", W'(busy), '0);
            end
            busy_cnt = 0;
        end else if (busy) busy_cnt++;
    end

    task automatic go(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit noise);
        exp_t e;
        int   lat;
        lat = W + 2;
`ifdef DIVIDE_ZERO_FAST_EN
        if (b == '0) lat = 1;
`endif
        e = model(a, b, s);
        e.cyc = cyc + 1 + lat;
        e.bsy = (lat == 1) ? 0 : W + 2;
        sb.push_back(e);
        dividend  = a;
        divisor   = b;
        signed_op = s;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        signed_op = 1'($urandom);
        if (noise && lat > 1) repeat (3) begin
            @(negedge clock);
            start    = 1'b1;
            dividend = $urandom;
            divisor  = $urandom;
            @(negedge clock);
            start    = 1'b0;
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (done) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL done_timeout at cycle %0d: got no done, want done within 100 cycles", cyc);
    endtask

    function automatic logic [W-1:0] pick(input bit den);
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0: v = den ? '0 : MIN;
            1: v = den ? '1 : '0;
            2: v = W'($urandom_range(1, 10));
            3: v = -W'($urandom_range(1, 10));
            4: v = W'($urandom) >> $urandom_range(0, W - 1);
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        repeat (2) @(negedge clock);
        chk("reset_quotient", quotient, '0);
        chk("reset_remainder", remainder, '0);
        chk("reset_flags", W'({busy, done, div_by_zero}), '0);
        clear_n = 1'b1;
        @(negedge clock);
        go(32'd100, 32'd7, 1'b0, 1'b1);
        wait_done();
        go(-32'sd7, 32'd2, 1'b1, 1'b1);
        wait_done();
        go(32'd7, -32'sd2, 1'b1, 1'b0);
        wait_done();
        go(MIN, '1, 1'b1, 1'b0);
        wait_done();
        go('1, 32'd2, 1'b0, 1'b0);
        wait_done();
        go(32'h1234, '0, 1'b0, 1'b0);
        wait_done();
        go(32'hFFFF_FFF0, '0, 1'b1, 1'b0);
        wait_done();
        go(32'd1000, 32'd10, 1'b0, 1'b0);
        wait_done();
        go(32'h1234, '0, 1'b0, 1'b0);
        wait_done();
        @(negedge clock);
        dividend  = 32'd50;
        divisor   = 32'd3;
        signed_op = 1'b0;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (9) @(negedge clock);
        #2;
        clear_n = 1'b0;
        #1;
        chk("abort_quotient", quotient, '0);
        chk("abort_remainder", remainder, '0);
        chk("abort_flags", W'({busy, done, div_by_zero}), '0);
        repeat (3) @(negedge clock);
        clear_n = 1'b1;
        @(negedge clock);
        go(32'd50, 32'd3, 1'b0, 1'b0);
        wait_done();
        for (int i = 0; i < 150; i++) begin
            go(pick(1'b0), pick(1'b1), 1'($urandom), 1'($urandom_range(0, 3) == 0));
            wait_done();
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clock);
        end
        repeat (3) @(negedge clock);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pending_results: got %0d outstanding, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
